// File: rtl/soc_defs.sv
// Shared SoC definitions for the SRAM-port responder: config window base, register
// offsets and the byte-lane merge helper used by every byte-writable storage element.
package soc_defs;

  localparam logic [31:0] CONF_BASE_DEF = 32'hbfaf_0000;

  localparam logic [15:0] CFG_LED     = 16'h0000;
  localparam logic [15:0] CFG_SWITCH  = 16'h0004;
  localparam logic [15:0] CFG_TIMER   = 16'h0008;
  localparam logic [15:0] CFG_SCRATCH = 16'h000c;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    REG_LED,
    REG_SWITCH,
    REG_TIMER,
    REG_SCRATCH,
    REG_NONE
  } cfg_reg_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  // addr[1:0] are don't-care: word access only
  function automatic cfg_reg_e cfg_decode(input logic [15:0] off);
    cfg_reg_e sel;
    case (off & 16'hfffc)
      CFG_LED:     sel = REG_LED;
      CFG_SWITCH:  sel = REG_SWITCH;
      CFG_TIMER:   sel = REG_TIMER;
      CFG_SCRATCH: sel = REG_SCRATCH;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sram_confreg_regs.sv
// Memory-mapped config registers (LED, switch, free-running timer, scratch, error counter)
// with byte-merge writes and a combinational read mux that shows the pre-write value.
module sram_confreg_regs
  import soc_defs::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req,
  input  logic [3:0]           wen,
  input  logic [15:0]          off,
  input  logic [31:0]          wdata,
  input  logic [7:0]           switch_in,
  output logic [31:0]          rd_data,
  output logic [15:0]          led,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  cfg_reg_e    sel;
  logic        wr;
  logic [31:0] timer;
  logic [31:0] timer_inc;
  logic [31:0] scratch;
  logic [31:0] led_merged;

  assign sel        = cfg_decode(off);
  assign wr         = req && (wen != 4'b0000);
  assign timer_inc  = timer + 32'd1;
  assign led_merged = byte_merge({16'h0000, led}, wdata, wen);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led     <= '0;
      timer   <= '0;
      scratch <= '0;
      err_cnt <= '0;
    end else begin
      // a timer write replaces that cycle's increment
      timer <= (wr && sel == REG_TIMER) ? byte_merge(timer, wdata, wen) : timer_inc;
      if (wr && sel == REG_LED)     led     <= led_merged[15:0];
      if (wr && sel == REG_SCRATCH) scratch <= byte_merge(scratch, wdata, wen);
      if (req && sel == REG_NONE && err_cnt != {ERR_CNT_W{1'b1}})
        err_cnt <= err_cnt + 1'b1;
    end
  end

  // plain timer reads see the value the counter takes at the request edge;
  // a same-request write returns the value held before the write
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_LED:     rd_data = {16'h0000, led};
      REG_SWITCH:  rd_data = {24'h000000, switch_in};
      REG_TIMER:   rd_data = wr ? timer : timer_inc;
      REG_SCRATCH: rd_data = scratch;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder side of the myCPU SRAM-style port: byte-writable word memory plus config
// window, read-first on writes, fixed RD_LAT-cycle read pipeline with no stalls.
module data_sram_responder
  import soc_defs::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEF
)
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sram_en,
  input  logic [3:0]           sram_wen,
  input  logic [31:0]          sram_addr,
  input  logic [31:0]          sram_wdata,
  output logic [31:0]          sram_rdata,
  output logic [15:0]          led,
  input  logic [7:0]           switch_in,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic              is_cfg;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem_word;
  logic [31:0]       cfg_word;
  logic [31:0]       rd_word;
  logic              exit_v;
  logic [31:0]       exit_d;

  logic [31:0] mem [2**ADDR_W];

  assign is_cfg   = (sram_addr[31:16] == CONF_BASE[31:16]);
  assign idx      = sram_addr[ADDR_W+1:2];
  assign mem_word = mem[idx];
  assign rd_word  = is_cfg ? cfg_word : mem_word;

  // array is intentionally not reset; contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (sram_en && !is_cfg) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  sram_confreg_regs u_regs (
    .clk       (clk),
    .resetn    (resetn),
    .req       (sram_en && is_cfg),
    .wen       (sram_wen),
    .off       (sram_addr[15:0]),
    .wdata     (sram_wdata),
    .switch_in (switch_in),
    .rd_data   (cfg_word),
    .led       (led),
    .err_cnt   (err_cnt)
  );

  // sram_rdata itself is the last stage, so only RD_LAT-1 extra registers sit in front
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign exit_v = sram_en;
      assign exit_d = rd_word;
    end else begin : g_pipe
      logic        stg_v [RD_LAT-1];
      logic [31:0] stg_d [RD_LAT-1];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < RD_LAT-1; i++) begin
            stg_v[i] <= 1'b0;
            stg_d[i] <= '0;
          end
        end else begin
          stg_v[0] <= sram_en;
          if (sram_en) stg_d[0] <= rd_word;
          for (int i = 1; i < RD_LAT-1; i++) begin
            stg_v[i] <= stg_v[i-1];
            stg_d[i] <= stg_d[i-1];
          end
        end
      end

      assign exit_v = stg_v[RD_LAT-2];
      assign exit_d = stg_d[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     sram_rdata <= '0;
    else if (exit_v) sram_rdata <= exit_d;
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Drives one stimulus stream into a latency-1 and a latency-3 responder and checks both
// against a word-map / register-variable reference model with a timestamped result history.
module tb_data_sram_responder;
  import soc_defs::*;

  localparam logic [31:0] CB = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  sw = '0;
  logic [31:0] rdata1, rdata3;
  logic [15:0] led1, led3;
  logic [7:0]  err1, err3;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(16), .RD_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
    .sram_wdata(wdata), .sram_rdata(rdata1), .led(led1), .switch_in(sw), .err_cnt(err1));

  data_sram_responder #(.ADDR_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
    .sram_wdata(wdata), .sram_rdata(rdata3), .led(led3), .switch_in(sw), .err_cnt(err3));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model
  typedef struct {bit v; bit k; logic [31:0] d;} beat_t;
  logic [31:0] mm [int];
  logic [15:0] m_led;
  logic [31:0] m_timer, m_scratch;
  int          m_err;
  beat_t       hist[$];
  bit          e1k, e3k;
  logic [31:0] e1, e3;

  function automatic logic [31:0] mmerge(input logic [31:0] c, input logic [31:0] d,
                                         input logic [3:0] w);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_led = '0; m_timer = '0; m_scratch = '0; m_err = 0;
    hist.delete();
    e1 = '0; e3 = '0; e1k = 1'b1; e3k = 1'b1;
  endtask

  task automatic model_edge();
    beat_t       b, x;
    bit          cfgsel, wr, twr;
    logic [15:0] off;
    logic [31:0] old_t, tmp;
    int          w;
    b.v = en; b.k = 1'b1; b.d = '0;
    cfgsel = (addr[31:16] == CB[31:16]);
    off    = addr[15:0] & 16'hfffc;
    wr     = en && (wen != 4'h0);
    twr    = wr && cfgsel && (off == 16'h0008);
    old_t  = m_timer;
    if (!twr) m_timer = m_timer + 32'd1;
    if (en) begin
      if (!cfgsel) begin
        w = int'(addr[17:2]);
        if (mm.exists(w)) b.d = mm[w]; else b.k = 1'b0;
        if (wr) begin
          if (b.k) mm[w] = mmerge(b.d, wdata, wen);
          else if (wen == 4'hf) mm[w] = wdata;
        end
      end else begin
        case (off)
          16'h0000: begin
            b.d = {16'h0, m_led};
            if (wr) begin tmp = mmerge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
          end
          16'h0004: b.d = {24'h0, sw};
          16'h0008: begin
            if (twr) begin b.d = old_t; m_timer = mmerge(old_t, wdata, wen); end
            else b.d = m_timer;
          end
          16'h000c: begin
            b.d = m_scratch;
            if (wr) m_scratch = mmerge(m_scratch, wdata, wen);
          end
          default: begin
            b.d = '0;
            if (m_err < 255) m_err++;
          end
        endcase
      end
    end
    hist.push_back(b);
    if (b.v) begin e1 = b.d; e1k = b.k; end
    if (hist.size() >= 3) begin
      x = hist[hist.size()-3];
      if (x.v) begin e3 = x.d; e3k = x.k; end
    end
    if (hist.size() > 3) void'(hist.pop_front());
  endtask

  task automatic check_outs();
    if (e1k) chk("rdata_lat1", rdata1, e1);
    if (e3k) chk("rdata_lat3", rdata3, e3);
    chk("led_lat1", {16'h0, led1}, {16'h0, m_led});
    chk("led_lat3", {16'h0, led3}, {16'h0, m_led});
    chk("err_lat1", {24'h0, err1}, 32'(m_err));
    chk("err_lat3", {24'h0, err3}, 32'(m_err));
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d; sw = 8'($urandom);
    @(posedge clk);
    if (resetn) model_edge();
    #1;
    check_outs();
  endtask

  logic [31:0] ra, rd;
  logic [15:0] offs [7];

  initial begin
    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000c, 16'h0010, 16'h0040, 16'hfffc};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata_lat1", rdata1, 32'h0);
    chk("reset_rdata_lat3", rdata3, 32'h0);
    chk("reset_led", {16'h0, led1}, 32'h0);
    chk("reset_err", {24'h0, err1}, 32'h0);
    resetn = 1'b1;

    // full write then read back
    step(1, 4'hf, 32'h0000_1000, 32'hdead_beef);
    step(1, 4'h0, 32'h0000_1000, 32'h0);
    chk("t1_read", rdata1, 32'hdead_beef);
    // partial lanes, addr[1:0] ignored
    step(1, 4'b0101, 32'h0000_1000, 32'h1122_3344);
    step(1, 4'h0, 32'h0000_1003, 32'h0);
    chk("t2_merge", rdata1, 32'hde22_be44);
    // read-first on back-to-back writes
    step(1, 4'hf, 32'h0000_2000, 32'ha5a5_a5a5);
    step(1, 4'hf, 32'h0000_2000, 32'h0);
    chk("t3_read_first", rdata1, 32'ha5a5_a5a5);
    step(1, 4'h0, 32'h0000_2000, 32'h0);
    chk("t3_after", rdata1, 32'h0);
    step(1, 4'hf, 32'h0000_3000, 32'h0c0c_0c0c);
    // timer wrap
    step(1, 4'hf, CB | 32'h8, 32'hffff_fffe);
    step(1, 4'h0, CB | 32'h8, 32'h0);
    chk("t4_timer_a", rdata1, 32'hffff_ffff);
    step(1, 4'h0, CB | 32'h8, 32'h0);
    chk("t4_timer_b", rdata1, 32'h0);
    // LED and error counter saturation
    step(1, 4'hf, CB, 32'hffff_1234);
    chk("t5_led", {16'h0, led1}, 32'h0000_1234);
    step(1, 4'h0, CB, 32'h0);
    chk("t5_led_read", rdata1, 32'h0000_1234);
    step(1, 4'hf, CB | 32'h4, 32'hffff_ffff);
    for (int i = 0; i < 300; i++) step(1, 4'hf, CB | 32'h40, $urandom);
    chk("t5_err_sat", {24'h0, err1}, 32'd255);
    step(1, 4'h0, CB | 32'h40, 32'h0);
    chk("t5_unmapped_read", rdata1, 32'h0);
    chk("t5_err_hold", {24'h0, err3}, 32'd255);

    // reset mid-flight drops beats, keeps memory
    repeat (3) step(0, 4'h0, 32'h0, 32'h0);
    step(1, 4'h0, 32'h0000_1000, 32'h0);
    step(1, 4'h0, 32'h0000_2000, 32'h0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_rdata_lat1", rdata1, 32'h0);
    chk("t6_rst_rdata_lat3", rdata3, 32'h0);
    chk("t6_rst_err", {24'h0, err3}, 32'h0);
    repeat (2) step(0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 4'h0, 32'h0, 32'h0);
      chk("t6_no_beats", rdata3, 32'h0);
    end
    step(1, 4'h0, 32'h0000_1000, 32'h0);
    chk("t6_mem_a", rdata1, 32'hde22_be44);
    step(1, 4'h0, 32'h0000_2000, 32'h0);
    chk("t6_mem_b", rdata1, 32'h0);
    step(1, 4'h0, 32'h0000_3000, 32'h0);
    chk("t6_mem_c", rdata1, 32'h0c0c_0c0c);
    step(0, 4'h0, 32'h0, 32'h0);
    step(0, 4'h0, 32'h0, 32'h0);
    chk("t6_mem_c_lat3", rdata3, 32'h0c0c_0c0c);

    // random traffic over a small aliased word pool and the config window
    for (int i = 0; i < 32; i++)
      step(1, 4'hf, (32'($urandom_range(0, 7)) << 18) | (32'(i) << 2), $urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7)
        ra = (32'($urandom_range(0, 7)) << 18) | (32'($urandom_range(0, 31)) << 2)
             | 32'($urandom_range(0, 3));
      else
        ra = CB | {16'h0, offs[$urandom_range(0, 6)]} | 32'($urandom_range(0, 3));
      rd = $urandom;
      step($urandom_range(0, 4) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
           ra, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
